// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single RegFile write port between ALU and load
// writeback, with a registered write stage and read-after-write operand bypass.
module regfile_wr_arbiter #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_wr,
  output logic [AW-1:0] rf_ad,
  output logic [DW-1:0] rf_rd,
  input  logic [AW-1:0] rd_aa,
  input  logic [AW-1:0] rd_ab,
  output logic [AW-1:0] rf_aa,
  output logic [AW-1:0] rf_ab,
  input  logic [DW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rb,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [7:0]    conflict_cnt
);

  // Handshake: a request transfers on a rising edge where valid & ready are both
  // high. ready is combinational, never high without its valid, at most one of
  // the two is high, and both are low during rst or hold. A requester keeps
  // valid/addr/data stable until it sees the transfer; nothing is buffered here.

  logic last_grant;  // index of the most recent winner; 1 means req0 wins next tie
  logic gnt0;
  logic gnt1;
  logic contended;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !hold) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign contended  = req0_valid && req1_valid && !hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr        <= 1'b0;
      rf_ad        <= '0;
      rf_rd        <= '0;
      last_grant   <= 1'b1;
      conflict_cnt <= 8'd0;
    end else begin
      if (gnt0) begin
        rf_wr      <= 1'b1;
        rf_ad      <= req0_addr;
        rf_rd      <= req0_data;
        last_grant <= 1'b0;
      end else if (gnt1) begin
        rf_wr      <= 1'b1;
        rf_ad      <= req1_addr;
        rf_rd      <= req1_data;
        last_grant <= 1'b1;
      end else begin
        rf_wr      <= 1'b0;
      end
      // Saturating: the counter sticks at 255 instead of wrapping.
      if (contended && (conflict_cnt != 8'hFF)) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end

  assign rf_aa = rd_aa;
  assign rf_ab = rd_ab;

  // Only the registered write is forwarded; the RegFile has not committed it yet.
  always_comb begin
    op_a = rf_ra;
    op_b = rf_rb;
    if (rf_wr && (rd_aa == rf_ad)) op_a = rf_rd;
    if (rf_wr && (rd_ab == rf_ad)) op_b = rf_rd;
  end

endmodule
